// File: rtl/duc_ddc_apb_initiator.sv
// APB3 initiator for the DUC/DDC core register port: turns a valid/ready command
// stream into single APB transfers, bounded by a wait-state timeout.
module duc_ddc_apb_initiator #(
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  sreg_presetn,
    output logic                  sreg_psel,
    output logic                  sreg_penable,
    output logic                  sreg_pwrite,
    output logic [ADDR_WIDTH-1:0] sreg_paddr,
    output logic [DATA_WIDTH-1:0] sreg_pwdata,
    input  logic [DATA_WIDTH-1:0] sreg_prdata,
    input  logic                  sreg_pready,
    input  logic                  sreg_pslverr
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    localparam logic [15:0] LP_WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t                r_state;
    state_t                w_next;
    logic [15:0]           r_wait_cnt;
    logic                  r_presetn_q1;
    logic                  r_presetn;
    logic                  r_psel;
    logic                  r_penable;
    logic                  r_pwrite;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;
    logic                  r_rsp_timeout;
    logic                  w_accept;
    logic                  w_expire;

    assign w_accept = (r_state == S_IDLE) && cmd_valid;
    assign w_expire = (r_state == S_ACCESS) && !sreg_pready && (r_wait_cnt == LP_WAIT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (cmd_valid) w_next = S_SETUP;
            S_SETUP:  w_next = S_ACCESS;
            S_ACCESS: if (sreg_pready || w_expire) w_next = S_RESP;
            S_RESP:   if (rsp_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // APB strobes and rsp_valid are registered from the next state so every output is a flop
    always_ff @(posedge clk) begin
        if (reset) begin
            r_presetn_q1  <= 1'b0;
            r_presetn     <= 1'b0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_wait_cnt    <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_presetn_q1 <= 1'b1;
            r_presetn    <= r_presetn_q1;
            r_psel       <= (w_next == S_SETUP) || (w_next == S_ACCESS);
            r_penable    <= (w_next == S_ACCESS);
            r_rsp_valid  <= (w_next == S_RESP);

            if (w_accept) begin
                r_pwrite <= cmd_write;
                r_paddr  <= cmd_addr;
                r_pwdata <= cmd_wdata;
            end

            if (r_state == S_SETUP) begin
                r_wait_cnt <= '0;
            end else if ((r_state == S_ACCESS) && !sreg_pready && !w_expire) begin
                r_wait_cnt <= r_wait_cnt + 16'd1;
            end

            // pready wins over an expiring counter in the same cycle
            if ((r_state == S_ACCESS) && sreg_pready) begin
                r_rsp_rdata   <= r_pwrite ? '0 : sreg_prdata;
                r_rsp_err     <= sreg_pslverr;
                r_rsp_timeout <= 1'b0;
            end else if (w_expire) begin
                r_rsp_rdata   <= '0;
                r_rsp_err     <= 1'b1;
                r_rsp_timeout <= 1'b1;
            end
        end
    end

    assign cmd_ready    = (r_state == S_IDLE) && !reset;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_rdata    = r_rsp_rdata;
    assign rsp_err      = r_rsp_err;
    assign rsp_timeout  = r_rsp_timeout;
    assign sreg_presetn = r_presetn;
    assign sreg_psel    = r_psel;
    assign sreg_penable = r_penable;
    assign sreg_pwrite  = r_pwrite;
    assign sreg_paddr   = r_paddr;
    assign sreg_pwdata  = r_pwdata;

endmodule

// File: tb/tb_duc_ddc_apb_initiator.sv
// Bench for duc_ddc_apb_initiator: table vectors, random transfers checked against
// a transaction-level model, and reset corner cases.
module tb_duc_ddc_apb_initiator;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err, rsp_timeout;
    logic          sreg_presetn, sreg_psel, sreg_penable, sreg_pwrite;
    logic [AW-1:0] sreg_paddr;
    logic [DW-1:0] sreg_pwdata, sreg_prdata;
    logic          sreg_pready, sreg_pslverr;

    int total = 0;
    int bad   = 0;

    duc_ddc_apb_initiator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .sreg_presetn(sreg_presetn), .sreg_psel(sreg_psel), .sreg_penable(sreg_penable),
        .sreg_pwrite(sreg_pwrite), .sreg_paddr(sreg_paddr), .sreg_pwdata(sreg_pwdata),
        .sreg_prdata(sreg_prdata), .sreg_pready(sreg_pready), .sreg_pslverr(sreg_pslverr)
    );

    always #5 clk = ~clk;

    // waits = access cycles before pready; waits >= TO means the slave never answers in time
    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            waits;
        logic [DW-1:0] prdata;
        logic          slverr;
        int            bp;
        logic          keepv;
        int            lat;
        logic [DW-1:0] e_rdata;
        logic          e_err;
        logic          e_to;
    } txn_t;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic txn_t model(input txn_t t);
        txn_t r = t;
        if (t.waits >= TO) begin
            r.lat = TO + 2; r.e_rdata = '0; r.e_err = 1'b1; r.e_to = 1'b1;
        end else begin
            r.lat = 3 + t.waits; r.e_rdata = t.write ? '0 : t.prdata;
            r.e_err = t.slverr; r.e_to = 1'b0;
        end
        return r;
    endfunction

    function automatic txn_t mk(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                                input int ws, input logic [DW-1:0] pr, input logic se,
                                input int bp, input logic kv, input int lat,
                                input logic [DW-1:0] er, input logic ee, input logic et);
        txn_t t;
        t.write = w; t.addr = a; t.wdata = wd; t.waits = ws; t.prdata = pr; t.slverr = se;
        t.bp = bp; t.keepv = kv; t.lat = lat; t.e_rdata = er; t.e_err = ee; t.e_to = et;
        return t;
    endfunction

    // Starts and ends at a negedge; the slave reacts to the observed ACCESS cycles.
    task automatic run_txn(input txn_t t);
        int acc = 0;
        cmd_valid = 1'b1; cmd_write = t.write; cmd_addr = t.addr; cmd_wdata = t.wdata;
        rsp_ready = 1'b0; sreg_prdata = t.prdata; sreg_pslverr = t.slverr; sreg_pready = 1'b0;
        chk("accept_ready", {31'd0, cmd_ready}, 32'd1);
        for (int k = 1; k <= t.lat; k++) begin
            @(posedge clk); @(negedge clk);
            if (!t.keepv) cmd_valid = 1'b0;
            chk("busy_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            if (k < t.lat) begin
                chk("psel", {31'd0, sreg_psel}, 32'd1);
                chk("penable", {31'd0, sreg_penable}, (k == 1) ? 32'd0 : 32'd1);
                chk("paddr", {20'd0, sreg_paddr}, {20'd0, t.addr});
                chk("pwrite", {31'd0, sreg_pwrite}, {31'd0, t.write});
                chk("pwdata", sreg_pwdata, t.wdata);
                chk("early_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            end else begin
                chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
                chk("resp_psel", {30'd0, sreg_psel, sreg_penable}, 32'd0);
                chk("rsp_rdata", rsp_rdata, t.e_rdata);
                chk("rsp_err", {31'd0, rsp_err}, {31'd0, t.e_err});
                chk("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, t.e_to});
            end
            sreg_pready = 1'b0;
            if (sreg_psel && sreg_penable) begin
                sreg_pready = (acc == t.waits);
                acc++;
            end
        end
        for (int b = 0; b < t.bp; b++) begin
            @(posedge clk); @(negedge clk);
            chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_rdata", rsp_rdata, t.e_rdata);
            chk("bp_err_to", {30'd0, rsp_err, rsp_timeout}, {30'd0, t.e_err, t.e_to});
            chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        rsp_ready = 1'b0;
        chk("post_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("post_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    endtask

    txn_t tbl[8];
    txn_t t;
    int   lowcnt;

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; sreg_prdata = '0; sreg_pready = 1'b0; sreg_pslverr = 1'b0;

        tbl[0] = mk(1'b1, 12'h010, 32'hDEADBEEF, 0, 32'h11111111, 1'b0, 0, 1'b0, 3, 32'h0, 1'b0, 1'b0);
        tbl[1] = mk(1'b0, 12'h004, 32'h0, 3, 32'h12345678, 1'b0, 0, 1'b0, 6, 32'h12345678, 1'b0, 1'b0);
        tbl[2] = mk(1'b0, 12'h020, 32'h0, 0, 32'hA5A50F0F, 1'b1, 0, 1'b0, 3, 32'hA5A50F0F, 1'b1, 1'b0);
        tbl[3] = mk(1'b0, 12'h030, 32'h0, 255, 32'h77777777, 1'b0, 0, 1'b0, 10, 32'h0, 1'b1, 1'b1);
        tbl[4] = mk(1'b0, 12'h040, 32'h0, 7, 32'hCAFEF00D, 1'b0, 0, 1'b0, 10, 32'hCAFEF00D, 1'b0, 1'b0);
        tbl[5] = mk(1'b1, 12'h050, 32'h01020304, 2, 32'h99999999, 1'b1, 0, 1'b0, 5, 32'h0, 1'b1, 1'b0);
        tbl[6] = mk(1'b0, 12'h7FF, 32'h0, 1, 32'h0BADF00D, 1'b0, 5, 1'b1, 4, 32'h0BADF00D, 1'b0, 1'b0);
        tbl[7] = mk(1'b1, 12'hFFF, 32'hFFFFFFFF, 0, 32'h0, 1'b0, 2, 1'b1, 3, 32'h0, 1'b0, 1'b0);

        // Power-on reset held for 3 edges: presetn must stay low for 4 sampled cycles
        lowcnt = 0;
        repeat (3) begin
            @(posedge clk); @(negedge clk);
            if (!sreg_presetn) lowcnt++;
        end
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_apb_ctl", {29'd0, sreg_psel, sreg_penable, sreg_pwrite}, 32'd0);
        chk("rst_paddr", {20'd0, sreg_paddr}, 32'd0);
        chk("rst_pwdata", sreg_pwdata, 32'd0);
        chk("rst_rsp", {29'd0, rsp_valid, rsp_err, rsp_timeout}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); @(negedge clk);
            if (sreg_presetn) break;
            lowcnt++;
        end
        chk("presetn_low_cycles", lowcnt, 32'd4);

        for (int i = 0; i < 8; i++) run_txn(tbl[i]);

        for (int i = 0; i < 24; i++) begin
            t.write  = 1'($urandom_range(0, 1));
            t.addr   = AW'($urandom);
            t.wdata  = $urandom;
            t.waits  = $urandom_range(0, TO + 2);
            t.prdata = $urandom;
            t.slverr = 1'($urandom_range(0, 1));
            t.bp     = $urandom_range(0, 3);
            t.keepv  = 1'($urandom_range(0, 1));
            run_txn(model(t));
        end

        // Reset while the core stalls in ACCESS
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h0A0; sreg_pready = 1'b0;
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        chk("mid_in_access", {30'd0, sreg_psel, sreg_penable}, 32'd3);
        reset = 1'b1;
        lowcnt = 0;
        @(posedge clk); @(negedge clk);
        if (!sreg_presetn) lowcnt++;
        chk("mid_rst_apb", {30'd0, sreg_psel, sreg_penable}, 32'd0);
        chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        @(posedge clk); @(negedge clk);
        if (!sreg_presetn) lowcnt++;
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); @(negedge clk);
            if (sreg_presetn) break;
            lowcnt++;
        end
        chk("mid_presetn_low_cycles", lowcnt, 32'd3);
        chk("mid_after_rsp_valid", {31'd0, rsp_valid}, 32'd0);

        run_txn(mk(1'b0, 12'h0A4, 32'h0, 1, 32'h5EED5EED, 1'b0, 0, 1'b0, 4, 32'h5EED5EED, 1'b0, 1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
